// File: rtl/lsr_cmd_scheduler_if.sv
// Request/response bus between the LSR requesters (host, auto-dim engine)
// and the command scheduler.
interface lsr_cmd_scheduler_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_cmd0;
   logic [3:0]  req_cmd1;
   logic [7:0]  req_op0;
   logic [7:0]  req_op1;
   logic [95:0] req_data0;
   logic [95:0] req_data1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [95:0] rsp_data;
   logic        rsp_src;

   modport slave (
      input  req_valid, req_cmd0, req_cmd1, req_op0, req_op1, req_data0, req_data1,
      output req_ready,
      output rsp_valid, rsp_data, rsp_src,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_cmd0, req_cmd1, req_op0, req_op1, req_data0, req_data1,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_src,
      output rsp_ready
   );
endinterface

// File: rtl/lsr_cmd_scheduler.sv
// Two-requester command scheduler for the LSR PWM datapath, one request in flight.
// Define LSR_SCHED_FIXED_PRIO_EN for fixed host priority instead of round-robin.
module lsr_cmd_scheduler (
   input  logic               sys_clk,
   input  logic               sys_resetb,
   lsr_cmd_scheduler_if.slave bus,
   output logic [3:0]         CMD,
   output logic [7:0]         Operand_ID,
   output logic [95:0]        DATA_i,
   output logic               init,
   output logic               CTS,
   input  logic [95:0]        DATA_o,
   output logic               busy
);

   localparam logic [3:0] CMD_LINEAR  = 4'b1001;
   localparam logic [3:0] CMD_SAVE    = 4'b1100;
   localparam logic [3:0] CMD_RESTORE = 4'b1101;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT, S_SAVE, S_CAPT, S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        src_q, src_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [7:0]  op_q, op_d;
   logic [95:0] data_q, data_d;
   logic        init_q, init_d;
   logic        cts_q, cts_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [95:0] rsp_data_q, rsp_data_d;
   logic        busy_q, busy_d;
`ifndef LSR_SCHED_FIXED_PRIO_EN
   logic        prio_q, prio_d;
`endif

   logic [1:0]  grant;
   logic        sel_src;
   logic [3:0]  sel_cmd;

   // Arbitration: only meaningful while IDLE; req_ready gates it to that state
   always_comb begin
      grant = 2'b00;
`ifdef LSR_SCHED_FIXED_PRIO_EN
      if (bus.req_valid[0])      grant = 2'b01;
      else if (bus.req_valid[1]) grant = 2'b10;
`else
      case (bus.req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
`endif
   end

   assign sel_src = grant[1];
   assign sel_cmd = sel_src ? bus.req_cmd1 : bus.req_cmd0;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      src_d       = src_q;
      cmd_d       = cmd_q;
      op_d        = op_q;
      data_d      = data_q;
      init_d      = 1'b0;
      cts_d       = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
`ifndef LSR_SCHED_FIXED_PRIO_EN
      prio_d      = prio_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|bus.req_valid) begin
               state_d = S_LOAD;
               src_d   = sel_src;
               cmd_d   = sel_cmd;
               op_d    = sel_src ? bus.req_op1   : bus.req_op0;
               data_d  = sel_src ? bus.req_data1 : bus.req_data0;
               init_d  = (sel_cmd == CMD_LINEAR) || (sel_cmd == CMD_RESTORE);
`ifndef LSR_SCHED_FIXED_PRIO_EN
               prio_d  = ~sel_src;
`endif
            end
         end
         S_LOAD: begin
            cnt_d = 5'd0;
            if ((cmd_q == CMD_LINEAR) || (cmd_q == CMD_RESTORE)) begin
               state_d = S_WAIT;
            end else if (cmd_q == CMD_SAVE) begin
               state_d = S_SAVE;
               cts_d   = 1'b1;
            end else begin
               state_d = S_CAPT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) state_d = S_CAPT;
         end
         S_SAVE: state_d = S_CAPT;
         S_CAPT: begin
            // Datapath drive returns to zero once the result is captured
            rsp_data_d  = DATA_o;
            rsp_valid_d = 1'b1;
            cmd_d       = 4'd0;
            op_d        = 8'd0;
            data_d      = 96'd0;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         src_q       <= 1'b0;
         cmd_q       <= 4'd0;
         op_q        <= 8'd0;
         data_q      <= 96'd0;
         init_q      <= 1'b0;
         cts_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 96'd0;
         busy_q      <= 1'b0;
`ifndef LSR_SCHED_FIXED_PRIO_EN
         prio_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         src_q       <= src_d;
         cmd_q       <= cmd_d;
         op_q        <= op_d;
         data_q      <= data_d;
         init_q      <= init_d;
         cts_q       <= cts_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
`ifndef LSR_SCHED_FIXED_PRIO_EN
         prio_q      <= prio_d;
`endif
      end
   end

   // Grant acknowledge is combinational so a strobe is accepted in the cycle it is seen
   assign bus.req_ready = ((state_q == S_IDLE) && sys_resetb) ? grant : 2'b00;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_src   = src_q;
   assign CMD           = cmd_q;
   assign Operand_ID    = op_q;
   assign DATA_i        = data_q;
   assign init          = init_q;
   assign CTS           = cts_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_lsr_cmd_scheduler.sv
// Scoreboard bench for lsr_cmd_scheduler with a behavioural PWM datapath model.
module tb_lsr_cmd_scheduler;
   logic        sys_clk = 1'b0;
   logic        sys_resetb = 1'b1;
   logic [3:0]  cmd;
   logic [7:0]  op_id;
   logic [95:0] data_i;
   logic [95:0] data_o;
   logic        init;
   logic        cts;
   logic        busy;

   lsr_cmd_scheduler_if bus();

   lsr_cmd_scheduler dut (
      .sys_clk    (sys_clk),
      .sys_resetb (sys_resetb),
      .bus        (bus),
      .CMD        (cmd),
      .Operand_ID (op_id),
      .DATA_i     (data_i),
      .init       (init),
      .CTS        (cts),
      .DATA_o     (data_o),
      .busy       (busy)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic        src;
      logic [95:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   init_pulses = 0;
   int   cts_pulses = 0;

   // Datapath model: linear = sat(duty*coeff + offset); save latches DATA_i; restore returns it
   function automatic logic [95:0] lin(input logic [95:0] d, input logic [7:0] op);
      logic [95:0]       r;
      int                v;
      logic signed [5:0] off;
      off = op[5:0];
      r = '0;
      for (int i = 0; i < 12; i++) begin
         v = int'(d[8*i +: 8]) * int'(op[7:6]) + int'(off);
         if (v > 255) v = 255;
         else if (v < 0) v = 0;
         r[8*i +: 8] = v[7:0];
      end
      return r;
   endfunction

   logic [95:0] dp_res = '0;
   logic [95:0] dp_save = '0;
   always @(posedge sys_clk) begin
      if (init) dp_res <= (cmd == 4'b1101) ? dp_save : lin(data_i, op_id);
      if (cts)  dp_save <= data_i;
   end
   assign data_o = ((cmd == 4'b1001) || (cmd == 4'b1101)) ? dp_res : data_i;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      sys_resetb = 1'b0;
      #2;
      chk("rst_ctrl", 96'({bus.req_ready, bus.rsp_valid, bus.rsp_src, init, cts, busy, cmd, op_id}), 96'd0);
      chk("rst_rsp_data", bus.rsp_data, 96'd0);
      chk("rst_data_i", data_i, 96'd0);
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_resetb = 1'b1;
   endtask

   task automatic issue(input int who, input logic [3:0] c, input logic [7:0] op,
                        input logic [95:0] d, input logic [95:0] exp, input bit push);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      @(posedge sys_clk);
      #1;
      if (who == 0) begin
         bus.req_cmd0 = c; bus.req_op0 = op; bus.req_data0 = d;
      end else begin
         bus.req_cmd1 = c; bus.req_op1 = op; bus.req_data1 = d;
      end
      bus.req_valid[who] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge sys_clk);
         if (bus.req_ready[who]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge sys_clk);
      #1;
      bus.req_valid[who] = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: requester %0d got no req_ready within 50 cycles", who);
      end else if (push) begin
         e.src  = (who == 1);
         e.data = exp;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if ((exp_q.size() == 0) && !busy) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL done_timeout: pending=%0d busy=%0b expected pending=0 busy=0", exp_q.size(), busy);
      end
   endtask

   localparam logic [95:0] D_SAVE = 96'h0102030405060708090A0B0C;
   localparam logic [95:0] D_HOLD = 96'hA5A5A5A55A5A5A5AC3C3C3C3;

   initial begin
      int   first_init, n_init, first_rsp, n_v, n;
      logic [1:0] exp_gnt;
      exp_t e;

      bus.req_valid = 2'b00;
      bus.req_cmd0 = '0;  bus.req_cmd1 = '0;
      bus.req_op0 = '0;   bus.req_op1 = '0;
      bus.req_data0 = '0; bus.req_data1 = '0;
      bus.rsp_ready = 1'b1;

      fork
         forever begin
            @(negedge sys_clk);
            if (sys_resetb) begin
               if (init) init_pulses++;
               if (cts)  cts_pulses++;
               if (bus.rsp_valid && bus.rsp_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_rsp: got src=%0b data=%h expected no response", bus.rsp_src, bus.rsp_data);
                  end else begin
                     e = exp_q.pop_front();
                     chk("rsp_data", bus.rsp_data, e.data);
                     chk("rsp_src", 96'(bus.rsp_src), 96'(e.src));
                  end
               end
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      do_reset();

      // Host linear, coeff 1 offset 0: identity, 19-cycle latency, single init pulse
      issue(0, 4'b1001, 8'h40, {12{8'h80}}, {12{8'h80}}, 1'b1);
      first_init = 0; n_init = 0; first_rsp = 0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge sys_clk);
         if (init) begin
            n_init++;
            if (first_init == 0) first_init = k;
         end
         if (bus.rsp_valid && (first_rsp == 0)) first_rsp = k;
         if (k == 5) begin
            chk("wait_cmd", 96'({busy, cmd, op_id}), 96'({1'b1, 4'b1001, 8'h40}));
            chk("wait_data", data_i, {12{8'h80}});
         end
      end
      chk("init_first", 96'(first_init), 96'd1);
      chk("init_width", 96'(n_init), 96'd1);
      chk("lat_linear", 96'(first_rsp), 96'd19);
      wait_done();

      // Engine save then host restore
      issue(1, 4'b1100, 8'h00, D_SAVE, D_SAVE, 1'b1);
      wait_done();
      chk("cts_after_save", 96'(cts_pulses), 96'd1);
      issue(0, 4'b1101, 8'h00, {12{8'h00}}, D_SAVE, 1'b1);
      wait_done();

      // Back-pressure in RESP; engine strobe raised then dropped must be ignored
      bus.rsp_ready = 1'b0;
      issue(0, 4'b0000, 8'h12, D_HOLD, D_HOLD, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (bus.rsp_valid) break;
      end
      bus.req_cmd1 = 4'b1001; bus.req_op1 = 8'h40; bus.req_data1 = {12{8'h77}};
      bus.req_valid[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         chk("hold_ctrl", 96'({bus.rsp_valid, bus.req_ready, busy, bus.rsp_src}), 96'(5'b10010));
         chk("hold_data", bus.rsp_data, D_HOLD);
      end
      @(posedge sys_clk);
      #1;
      bus.req_valid[1] = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_done();

      // Reset during WAIT at count 7 aborts the request silently
      issue(0, 4'b1001, 8'h40, {12{8'h33}}, {12{8'h33}}, 1'b0);
      for (int k = 1; k <= 9; k++) @(negedge sys_clk);
      do_reset();
      n_v = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sys_clk);
         if (bus.rsp_valid) n_v++;
      end
      chk("abort_no_rsp", 96'(n_v), 96'd0);
      chk("abort_busy", 96'(busy), 96'd0);

      // Linear coeff 3 offset -1 on 0x90 saturates to 0xFF
      issue(0, 4'b1001, 8'hFF, {12{8'h90}}, {12{8'hFF}}, 1'b1);
      wait_done();

      // Both requesters continuously valid from a fresh reset
      do_reset();
      @(posedge sys_clk);
      #1;
      bus.req_cmd0 = 4'b0000; bus.req_op0 = 8'h00; bus.req_data0 = {12{8'h11}};
      bus.req_cmd1 = 4'b0000; bus.req_op1 = 8'h00; bus.req_data1 = {12{8'h22}};
      bus.req_valid = 2'b11;
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge sys_clk);
         if (bus.req_ready != 2'b00) begin
`ifdef LSR_SCHED_FIXED_PRIO_EN
            exp_gnt = 2'b01;
`else
            exp_gnt = n[0] ? 2'b10 : 2'b01;
`endif
            chk("grant", 96'(bus.req_ready), 96'(exp_gnt));
            e.src  = bus.req_ready[1];
            e.data = bus.req_ready[1] ? {12{8'h22}} : {12{8'h11}};
            exp_q.push_back(e);
            n++;
         end
      end
      @(posedge sys_clk);
      #1;
      bus.req_valid = 2'b00;
      chk("grant_count", 96'(n), 96'd4);
      wait_done();

      chk("queue_empty", 96'(exp_q.size()), 96'd0);
      chk("init_pulses", 96'(init_pulses), 96'd4);
      chk("cts_pulses", 96'(cts_pulses), 96'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
